// File: rtl/ingre_tracker_disp_if.sv
// Pulse, pixel-stream and status bundle between game logic / OLED mux and ingre_tracker_disp.
interface ingre_tracker_disp_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] use_pulse;
  logic [NUM_CH-1:0] restock_pulse;
  logic [12:0]       pix_index;
  logic [15:0]       oled;
  logic [NUM_CH-1:0] empty_flags;
  logic              any_empty;

  modport master (
    output use_pulse, restock_pulse, pix_index,
    input  oled, empty_flags, any_empty
  );

  modport slave (
    input  use_pulse, restock_pulse, pix_index,
    output oled, empty_flags, any_empty
  );
endinterface

// File: rtl/ingre_tracker_disp.sv
// Per-channel saturating ingredient stock counters rendered as stacked 3x5 digits on the OLED stream.
// Optional macro BLINK_EMPTY_EN: empty channels blink with a half-period of BLINK_DIV clocks.
module ingre_tracker_disp #(
  parameter int          NUM_CH     = 4,
  parameter int          MAX_COUNT  = 9,
  parameter int          INIT_COUNT = 2,
  parameter int          X_POS      = 80,
  parameter int          Y_BASE     = 2,
  parameter int          Y_STEP     = 8,
  parameter logic [15:0] FG_COL     = 16'h0000,
  parameter logic [15:0] BG_COL     = 16'b11111_101110_11011
`ifdef BLINK_EMPTY_EN
  , parameter logic [23:0] BLINK_DIV = 24'd3_125_000
`endif
) (
  input logic                clk,
  input logic                reset,
  ingre_tracker_disp_if.slave bus
);

  logic [3:0]        count [NUM_CH];
  logic [NUM_CH-1:0] zero_vec;
  logic [NUM_CH-1:0] empty_q;
  logic              any_q;

  logic              hit_d, hit_q;
  logic [2:0]        ch_d, ch_q;
  logic [2:0]        row_d, row_q;
  logic [1:0]        col_d, col_q;

  logic [3:0]        cur_count;
  logic [14:0]       glyph;
  logic [3:0]        bit_lin;
  logic              pix_on;
  logic              hide;
  logic [15:0]       oled_q;

  function automatic logic [14:0] font_glyph(input logic [3:0] d);
    case (d)
      4'd0:    font_glyph = 15'b111_101_101_101_111;
      4'd1:    font_glyph = 15'b110_010_010_010_111;
      4'd2:    font_glyph = 15'b111_001_111_100_111;
      4'd3:    font_glyph = 15'b111_001_111_001_111;
      4'd4:    font_glyph = 15'b101_101_111_001_001;
      4'd5:    font_glyph = 15'b111_100_111_001_111;
      4'd6:    font_glyph = 15'b111_100_111_101_111;
      4'd7:    font_glyph = 15'b111_001_001_001_001;
      4'd8:    font_glyph = 15'b111_101_111_101_111;
      4'd9:    font_glyph = 15'b111_101_111_001_111;
      default: font_glyph = 15'b0;
    endcase
  endfunction

  // Simultaneous use and restock cancel out; both directions saturate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) count[c] <= 4'(INIT_COUNT);
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.use_pulse[c] && !bus.restock_pulse[c] && count[c] != 4'd0)
          count[c] <= count[c] - 4'd1;
        else if (bus.restock_pulse[c] && !bus.use_pulse[c] && count[c] < 4'(MAX_COUNT))
          count[c] <= count[c] + 4'd1;
      end
    end
  end

  always_comb begin
    zero_vec = '0;
    for (int c = 0; c < NUM_CH; c++) zero_vec[c] = (count[c] == 4'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      empty_q <= {NUM_CH{INIT_COUNT == 0}};
      any_q   <= (INIT_COUNT == 0);
    end else begin
      empty_q <= zero_vec;
      any_q   <= |zero_vec;
    end
  end

  // Stage 1: locate the pixel inside a channel glyph; lowest channel wins on overlap.
  always_comb begin
    int xi;
    int yi;
    int base;
    hit_d = 1'b0;
    ch_d  = '0;
    row_d = '0;
    col_d = '0;
    xi    = int'(bus.pix_index) % 96;
    yi    = int'(bus.pix_index) / 96;
    base  = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      base = Y_BASE + c * Y_STEP;
      if (!hit_d && bus.pix_index < 13'd6144 &&
          xi >= X_POS && xi <= X_POS + 2 && yi >= base && yi <= base + 4) begin
        hit_d = 1'b1;
        ch_d  = 3'(c);
        row_d = 3'(yi - base);
        col_d = 2'(xi - X_POS);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q <= 1'b0;
      ch_q  <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      hit_q <= hit_d;
      ch_q  <= ch_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  always_comb begin
    cur_count = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (ch_q == 3'(c)) cur_count = count[c];
    glyph   = font_glyph(cur_count);
    bit_lin = 4'(row_q) * 4'd3 + 4'(col_q);
    pix_on  = glyph[4'd14 - bit_lin];
  end

`ifdef BLINK_EMPTY_EN
  logic [23:0] blink_cnt;
  logic        blink_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_DIV - 24'd1) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 24'd1;
    end
  end

  always_comb hide = blink_phase && (cur_count == 4'd0);
`else
  always_comb hide = 1'b0;
`endif

  // Stage 2: font lookup uses the count as it stands now, not when the pixel entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) oled_q <= BG_COL;
    else       oled_q <= (hit_q && pix_on && !hide) ? FG_COL : BG_COL;
  end

  assign bus.oled        = oled_q;
  assign bus.empty_flags = empty_q;
  assign bus.any_empty   = any_q;

endmodule

// File: tb/tb_ingre_tracker_disp.sv
// Directed bench for ingre_tracker_disp: counter saturation, empty flags, glyph rendering and async reset.
module tb_ingre_tracker_disp;

  localparam logic [15:0] FG = 16'h0000;
  localparam logic [15:0] BG = 16'b11111_101110_11011;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ingre_tracker_disp_if #(.NUM_CH(4)) bus();

  ingre_tracker_disp #(.NUM_CH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic [3:0] use_m, input logic [3:0] restock_m);
    bus.use_pulse     = use_m;
    bus.restock_pulse = restock_m;
    tick();
    bus.use_pulse     = '0;
    bus.restock_pulse = '0;
  endtask

  task automatic setPixel(input int x, input int y);
    bus.pix_index = 13'(y * 96 + x);
  endtask

  task automatic checkPixel(input string tag, input int x, input int y, input logic [15:0] expected);
    setPixel(x, y);
    tick();
    tick();
    checkOutput(tag, bus.oled, expected);
  endtask

  initial begin
    reset             = 1'b1;
    bus.use_pulse     = '0;
    bus.restock_pulse = '0;
    bus.pix_index     = '0;
    #2;
    checkOutput("reset_oled", bus.oled, BG);
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset_empty", 16'(bus.empty_flags), 16'h0);
    checkOutput("reset_any", 16'(bus.any_empty), 16'h0);

    // All channels start at 2; row0 of digit 2 is 111, row1 is 001.
    checkPixel("ch0_d2_r0c0", 80, 2, FG);
    checkPixel("ch0_d2_r1c1", 81, 3, BG);
    checkPixel("ch0_d2_r0c2", 82, 2, FG);
    checkPixel("left_of_glyph", 79, 2, BG);
    checkPixel("right_of_glyph", 83, 2, BG);
    checkPixel("gap_row", 80, 7, BG);

    // Two-cycle latency: still BG one clock after moving onto a lit pixel.
    setPixel(80, 4);
    tick();
    checkOutput("latency_1clk", bus.oled, BG);
    tick();
    checkOutput("latency_2clk", bus.oled, FG);

    // Channel 1 drained to zero, then one extra use.
    applyStimulus(4'b0010, 4'b0000);
    applyStimulus(4'b0010, 4'b0000);
    applyStimulus(4'b0010, 4'b0000);
    tick();
    checkOutput("ch1_empty_flags", 16'(bus.empty_flags), 16'h0002);
    checkOutput("ch1_any_empty", 16'(bus.any_empty), 16'h1);
    applyStimulus(4'b0010, 4'b0000);
    tick();
    checkOutput("ch1_hold_zero_flags", 16'(bus.empty_flags), 16'h0002);
    checkPixel("ch1_d0_r1c1", 81, 11, BG);
    checkPixel("ch1_d0_r1c0", 80, 11, FG);
    checkPixel("ch1_d0_r2c2", 82, 12, FG);

    // Channel 0 restocked ten times saturates at 9 (row3 = 001).
    for (int i = 0; i < 10; i++) applyStimulus(4'b0000, 4'b0001);
    checkPixel("ch0_d9_r3c0", 80, 5, BG);
    checkPixel("ch0_d9_r3c2", 82, 5, FG);
    checkPixel("ch0_d9_r1c1", 81, 3, BG);

    // Channel 2: use and restock together leave the count at 2 (row3 = 100).
    applyStimulus(4'b0100, 4'b0100);
    tick();
    checkOutput("ch2_both_flags", 16'(bus.empty_flags), 16'h0002);
    checkPixel("ch2_d2_r1c0", 80, 19, BG);
    checkPixel("ch2_d2_r3c0", 80, 21, FG);
    applyStimulus(4'b0000, 4'b0100);
    checkPixel("ch2_d3_r3c0", 80, 21, BG);

    checkPixel("out_of_range", 0, 0, FG == BG ? FG : BG);
    bus.pix_index = 13'd8191;
    tick();
    tick();
    checkOutput("index_8191", bus.oled, BG);

    // Channel 3 emptied, then an asynchronous reset mid-frame.
    applyStimulus(4'b1000, 4'b0000);
    applyStimulus(4'b1000, 4'b0000);
    tick();
    checkOutput("ch3_empty_flags", 16'(bus.empty_flags), 16'h000a);
    checkPixel("ch3_d0_r1c0", 80, 27, FG);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_oled", bus.oled, BG);
    checkOutput("async_reset_flags", 16'(bus.empty_flags), 16'h0);
    checkOutput("async_reset_any", 16'(bus.any_empty), 16'h0);
    tick();
    reset = 1'b0;
    checkPixel("ch3_d2_r1c0", 80, 27, BG);
    checkPixel("ch3_d2_r1c2", 82, 27, FG);
    checkPixel("ch1_d2_r1c0", 80, 11, BG);
    checkPixel("ch0_d2_r3c0", 80, 5, FG);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
